accel_port_buffer: RTL

ACCEL_PORT_BUFFER -- requirements
Module: accel_port_buffer

---
 rtl/accel_port_buffer_pkg.sv | 16 +
 rtl/accel_port_buffer_sync_fifo.sv | 79 +++++++
 rtl/accel_port_buffer.sv | 90 +++++++++
 3 files changed

// File: rtl/accel_port_buffer_pkg.sv
// accel_port_buffer_pkg: shared defaults and the count-width helper for the port buffer.
//   WIDTH_DEF / DEPTH_DEF : default data width and entries per direction
//   clog2(v)              : ceil(log2(v)), 0 for v<=1
package accel_port_buffer_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/accel_port_buffer_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered 1-cycle read data and registered level flags.
//   wr_en/wr_data    : push request; accepted when not full, or when full with a same-cycle accepted read
//   rd_en            : pop request; accepted only when count>0 (no fall-through at empty)
//   rd_data/rd_valid : popped word one cycle after the accepted read; data holds otherwise
//   count/empty/full : registered occupancy and flags, always consistent with each other
//   wr_acc/rd_acc    : combinational acceptance, used by the parent for error detection
module sync_fifo
    import accel_port_buffer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         rd_valid,
    output logic [clog2(DEPTH+1)-1:0]    count,
    output logic                         empty,
    output logic                         full,
    output logic                         wr_acc,
    output logic                         rd_acc
);

    localparam int CW = clog2(DEPTH + 1);
    localparam int PW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp_q, rp_q, wp_d, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             empty_q, full_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    assign rd_acc = rd_en && !empty_q;
    assign wr_acc = wr_en && (!full_q || rd_acc);

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_comb begin
        wp_d  = wr_acc ? ((wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1)) : wp_q;
        rp_d  = rd_acc ? ((rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + PW'(1)) : rp_q;
        cnt_d = (wr_acc && !rd_acc) ? cnt_q + CW'(1) :
                (rd_acc && !wr_acc) ? cnt_q - CW'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
            empty_q    <= (cnt_d == '0);
            full_q     <= (cnt_d == CW'(DEPTH));
            rd_valid_q <= rd_acc;
            if (rd_acc) rd_data_q <= mem[rp_q];
        end
    end

    // Storage is not reset; a simultaneous read of the same slot sees the old word.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wp_q] <= wr_data;
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign count    = cnt_q;
    assign empty    = empty_q;
    assign full     = full_q;

endmodule

// File: rtl/accel_port_buffer.sv
// accel_port_buffer: bidirectional bus<->accelerator buffer built from two sync_fifo instances.
//   bus_wr_en/bus_wr_data        : bus push into the to-side
//   acc_get_req/acc_get_data/_valid : accelerator pop from the to-side (1-cycle latency)
//   acc_put_req/acc_put_data     : accelerator push into the from-side
//   bus_rd_en/bus_rd_data/_valid : bus pop from the from-side (1-cycle latency)
//   to_/from_ empty, full, count : level information for the bus controller
//   to_ovf, from_udf, err_clr    : sticky error flags and their clear
module accel_port_buffer
    import accel_port_buffer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bus_wr_en,
    input  logic [WIDTH-1:0]          bus_wr_data,
    input  logic                      bus_rd_en,
    output logic [WIDTH-1:0]          bus_rd_data,
    output logic                      bus_rd_valid,
    input  logic                      acc_get_req,
    output logic [WIDTH-1:0]          acc_get_data,
    output logic                      acc_get_valid,
    input  logic                      acc_put_req,
    input  logic [WIDTH-1:0]          acc_put_data,
    output logic                      to_empty,
    output logic                      to_full,
    output logic                      from_empty,
    output logic                      from_full,
    output logic [clog2(DEPTH+1)-1:0] to_count,
    output logic [clog2(DEPTH+1)-1:0] from_count,
    output logic                      to_ovf,
    output logic                      from_udf,
    input  logic                      err_clr
);

    logic to_wr_acc, to_rd_acc, from_wr_acc, from_rd_acc;
    logic ovf_ev, udf_ev;
    logic to_ovf_q, from_udf_q;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_to (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (bus_wr_en),
        .wr_data  (bus_wr_data),
        .rd_en    (acc_get_req),
        .rd_data  (acc_get_data),
        .rd_valid (acc_get_valid),
        .count    (to_count),
        .empty    (to_empty),
        .full     (to_full),
        .wr_acc   (to_wr_acc),
        .rd_acc   (to_rd_acc)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_from (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (acc_put_req),
        .wr_data  (acc_put_data),
        .rd_en    (bus_rd_en),
        .rd_data  (bus_rd_data),
        .rd_valid (bus_rd_valid),
        .count    (from_count),
        .empty    (from_empty),
        .full     (from_full),
        .wr_acc   (from_wr_acc),
        .rd_acc   (from_rd_acc)
    );

    // Any dropped push, from either side, is reported through the one overflow flag.
    // A get at empty is harmless for the accelerator, so only bus underflow is flagged.
    assign ovf_ev = (bus_wr_en && !to_wr_acc) || (acc_put_req && !from_wr_acc);
    assign udf_ev = bus_rd_en && !from_rd_acc;

    // A new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_ovf_q   <= 1'b0;
            from_udf_q <= 1'b0;
        end else begin
            to_ovf_q   <= ovf_ev ? 1'b1 : (err_clr ? 1'b0 : to_ovf_q);
            from_udf_q <= udf_ev ? 1'b1 : (err_clr ? 1'b0 : from_udf_q);
        end
    end

    assign to_ovf   = to_ovf_q;
    assign from_udf = from_udf_q;

endmodule
